mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
- Parametrised successor to the team's fixed 4-bit counter: WIDTH-bit up/down counter with programmable modulus (0..MAX).
- Adds synchronous clear, parallel load, count enable, and direction control.
- Wrap or saturate mode is selected at elaboration.
- Terminal-count output allows cascading; a sticky overflow flag records boundary events.
- Used as the generic counter for lab timers, display scanners and dividers.

Parameters:
- WIDTH, 4: counter width in bits, 1..32.
- MAX, 15: terminal value; count range is 0..MAX; must be ≤ 2^WIDTH−1.
- SATURATE, 0: 0 = wrap at the boundary; 1 = hold at the boundary.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of count and ovf.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- en  in  1  count enable; also serves as cascade carry-in.
- up  in  1  direction: 1 = increment, 0 = decrement.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational.
- ovf  out  1  sticky boundary-event flag, registered.

Behaviour:
- Reset:
  - Asynchronous, active-high, one clock; rst asserted forces count=0 and ovf=0 immediately, regardless of clk.
  - Release is synchronous to the next rising edge; the first update occurs on the first rising edge with rst low.
- Priority each rising edge: rst > clear > load > en. Exactly one action per edge.
- clear=1: count←0, ovf←0. load and en are ignored.
- load=1 (clear=0):
  - count←load_val if load_val ≤ MAX, else count←MAX (clamp).
  - ovf unchanged; en ignored on this edge.
- en=1, up=1 (no clear/load):
  - count<MAX: count←count+1.
  - count=MAX: SATURATE=0 gives count←0; SATURATE=1 holds MAX. Either way ovf←1.
- en=1, up=0 (no clear/load):
  - count>0: count←count−1.
  - count=0: SATURATE=0 gives count←MAX; SATURATE=1 holds 0. Either way ovf←1.
- en=0 (no clear/load): count and ovf hold.
- tc = en & ~clear & ~load & ((up & count==MAX) | (~up & count==0)).
  - Asserted in the cycle before the boundary event.
  - Feeds the next stage's en for cascading.
  - tc is 0 while rst is asserted.
- Latency: count changes one clock after the controlling input is sampled. tc has zero latency from inputs.
- Arithmetic: all comparisons are unsigned at WIDTH bits. Increment and decrement never form a WIDTH+1 carry into count.
- Direction change: an up change takes effect on the same edge it is sampled; no dead cycle.
- MAX = 2^WIDTH−1: natural binary wrap, identical behaviour.
- MAX = 0: count is always 0. tc=en whenever no clear/load. Every enabled edge sets ovf.
- Reset mid-count: count→0 asynchronously; pending load/en on that edge is discarded.
- Simultaneous clear and load: clear wins, and ovf is cleared.
- Elaboration check: MAX > 2^WIDTH−1 or WIDTH < 1 is a fatal elaboration error.

Decomposition:
- Shared package counter_pkg:
  - Mode constants CNT_WRAP=0, CNT_SAT=1.
  - Function clog2 for callers sizing WIDTH from a modulus.
- No sub-module. Structure is a single sequential always block for count/ovf plus a continuous assign for tc.
- Cascades are built by instantiating multiple mod_updown_counter instances at the top level.

Test Plan:
- Reset: pulse rst mid-cycle at count=7 → count=0 and ovf=0 before the next clk edge; first en edge after release gives count=1.
- Wrap up (WIDTH=4, MAX=9, SATURATE=0):
  - en=1, up=1 from 0 for 10 edges → count 0..9 then 0.
  - tc=1 only while count=9.
  - ovf=1 after the 9→0 edge.
- Saturate down (MAX=9, SATURATE=1): load 2, then en=1, up=0 for 4 edges → count 1, 0, 0, 0; ovf=1 from the third edge; tc=1 while count=0.
- Load clamp and priority (MAX=9):
  - load_val=12, load=1 → count=9.
  - load=1 with clear=1 → count=0, ovf=0.
  - load=1 with en=1, load_val=3 → count=3, not 4.
- Cascade: two MAX=9 instances, tc of the low stage drives en of the high stage. 100 enabled edges from 00 → reads 99 then 00; high-stage ovf=1 only after the 99→00 edge.
- Direction flip and full range (WIDTH=4, MAX=15): count to 15, flip up=0 on the next edge → 14; count down to 0 then one more edge → 15, ovf=1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the generic up/down counter family.
package counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Bits needed to hold values 0..n-1 (at least 1), for sizing WIDTH from a modulus.
    function automatic int clog2(input longint unsigned n);
        int              r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// WIDTH-bit up/down counter with programmable terminal value MAX, wrap or saturate
// at the boundary, cascadable terminal count and a sticky boundary-event flag.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MAX      = 15,
    parameter int              SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 1 || WIDTH > 32 || MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_params
        $fatal(1, "mod_updown_counter: WIDTH must be 1..32 and MAX must fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    // Next value for an enabled step; the boundary case wraps or holds by mode.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] c, input logic dir);
        logic [WIDTH-1:0] r;
        if (dir) begin
            if (c == MAX_V) r = (SATURATE != CNT_WRAP) ? MAX_V : '0;
            else            r = c + WIDTH'(1);
        end else begin
            if (c == '0)    r = (SATURATE != CNT_WRAP) ? '0 : MAX_V;
            else            r = c - WIDTH'(1);
        end
        return r;
    endfunction

    logic at_boundary;

    assign at_boundary = up ? (count == MAX_V) : (count == '0);

    // tc is gated by rst so a held reset never looks like a carry to the next stage.
    assign tc = en & ~clear & ~load & ~rst & at_boundary;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= clamp_load(load_val);
        end else if (en) begin
            count <= step(count, up);
            if (at_boundary) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomised scoreboard bench for mod_updown_counter: wrap, saturate, full-range,
// MAX=0 and a two-stage decimal cascade, all checked against an arithmetic model.
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0, load = 1'b0, en = 1'b0, up = 1'b1;
    logic [3:0] load_val = 4'd0;
    logic       cen = 1'b0, cup = 1'b1, cclr = 1'b0;

    logic [3:0] wrap_cnt, sat_cnt, full_cnt, lo_cnt, hi_cnt;
    logic [1:0] zero_cnt;
    logic       wrap_tc, sat_tc, full_tc, zero_tc, lo_tc, hi_tc;
    logic       wrap_ovf, sat_ovf, full_ovf, zero_ovf, lo_ovf, hi_ovf;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(wrap_cnt), .tc(wrap_tc), .ovf(wrap_ovf));
    mod_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(sat_cnt), .tc(sat_tc), .ovf(sat_ovf));
    mod_updown_counter #(.WIDTH(4), .MAX(15), .SATURATE(0)) u_full (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(full_cnt), .tc(full_tc), .ovf(full_ovf));
    mod_updown_counter #(.WIDTH(2), .MAX(0), .SATURATE(0)) u_zero (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val[1:0]),
        .en(en), .up(up), .count(zero_cnt), .tc(zero_tc), .ovf(zero_ovf));
    mod_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(0)) u_lo (
        .clk(clk), .rst(rst), .clear(cclr), .load(1'b0), .load_val(4'd0),
        .en(cen), .up(cup), .count(lo_cnt), .tc(lo_tc), .ovf(lo_ovf));
    mod_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(0)) u_hi (
        .clk(clk), .rst(rst), .clear(cclr), .load(1'b0), .load_val(4'd0),
        .en(lo_tc), .up(cup), .count(hi_cnt), .tc(hi_tc), .ovf(hi_ovf));

    logic [5:0]      act_tc, act_ovf;
    logic [5:0][3:0] act_cnt;
    assign act_tc  = {hi_tc, lo_tc, zero_tc, full_tc, sat_tc, wrap_tc};
    assign act_ovf = {hi_ovf, lo_ovf, zero_ovf, full_ovf, sat_ovf, wrap_ovf};
    assign act_cnt = {hi_cnt, lo_cnt, {2'b00, zero_cnt}, full_cnt, sat_cnt, wrap_cnt};

    typedef struct packed {
        logic [5:0]      tc;
        logic [5:0][3:0] cnt;
        logic [5:0]      ovf;
    } item_t;

    item_t sb[$];

    localparam int MX  [6] = '{9, 9, 15, 0, 9, 9};
    localparam bit SAT [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    string names [6] = '{"wrap", "sat", "full", "zero", "lo", "hi"};

    int m_cnt [6] = '{0, 0, 0, 0, 0, 0};
    bit m_ovf [6] = '{0, 0, 0, 0, 0, 0};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural rule: clear > load(clamped) > enabled step by modular or clamped arithmetic.
    function automatic void mstep(input int mx, input bit sat, input bit clr, input bit ld,
                                  input int lv, input bit e, input bit u,
                                  inout int c, inout bit o, output bit t);
        t = e && !clr && !ld && (u ? (c == mx) : (c == 0));
        if (clr) begin
            c = 0;
            o = 1'b0;
        end else if (ld) begin
            c = (lv > mx) ? mx : lv;
        end else if (e) begin
            if ((u && c == mx) || (!u && c == 0)) o = 1'b1;
            if (sat) c = u ? ((c + 1 > mx) ? mx : c + 1) : ((c - 1 < 0) ? 0 : c - 1);
            else     c = u ? (c + 1) % (mx + 1) : (c + mx) % (mx + 1);
        end
    endfunction

    task automatic drive(input bit clr, input bit ld, input int lv, input bit e, input bit u,
                         input bit ce, input bit cu, input bit cc);
        item_t it;
        bit    t;
        @(negedge clk);
        clear = clr; load = ld; load_val = 4'(lv); en = e; up = u;
        cen = ce; cup = cu; cclr = cc;
        for (int i = 0; i < 4; i++) begin
            mstep(MX[i], SAT[i], clr, ld, (i == 3) ? (lv & 3) : lv, e, u, m_cnt[i], m_ovf[i], t);
            it.tc[i] = t; it.cnt[i] = 4'(m_cnt[i]); it.ovf[i] = m_ovf[i];
        end
        mstep(9, 1'b0, cc, 1'b0, 0, ce, cu, m_cnt[4], m_ovf[4], t);
        it.tc[4] = t; it.cnt[4] = 4'(m_cnt[4]); it.ovf[4] = m_ovf[4];
        mstep(9, 1'b0, cc, 1'b0, 0, t, cu, m_cnt[5], m_ovf[5], t);
        it.tc[5] = t; it.cnt[5] = 4'(m_cnt[5]); it.ovf[5] = m_ovf[5];
        sb.push_back(it);
    endtask

    // Monitor: tc mid-cycle with inputs settled, count/ovf just after the edge.
    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                for (int i = 0; i < 6; i++) chk({names[i], ".tc"}, act_tc[i], it.tc[i]);
                @(posedge clk);
                #1;
                for (int i = 0; i < 6; i++) begin
                    chk({names[i], ".count"}, act_cnt[i], it.cnt[i]);
                    chk({names[i], ".ovf"}, act_ovf[i], it.ovf[i]);
                end
            end
        end
    end

    initial begin : stim
        int waited;
        #1 rst = 1'b1;
        #1;
        chk("reset.full.count", full_cnt, 0);
        chk("reset.wrap.ovf", wrap_ovf, 0);
        chk("reset.zero.tc", zero_tc, 0);
        @(negedge clk);
        rst = 1'b0; load = 1'b1; load_val = 4'd6;
        @(posedge clk); #1;
        chk("pre.full.load6", full_cnt, 6);
        @(negedge clk);
        load = 1'b0; en = 1'b1; up = 1'b1;
        @(posedge clk); #1;
        chk("pre.full.count7", full_cnt, 7);
        chk("pre.zero.ovf", zero_ovf, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async.full.count", full_cnt, 0);
        chk("async.zero.ovf", zero_ovf, 0);
        chk("async.zero.tc", zero_tc, 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("release.full.count", full_cnt, 1);

        // Directed: wrap up through MAX, saturating descent, load clamp and priority.
        drive(1, 0, 0, 0, 1, 0, 1, 1);
        repeat (12) drive(0, 0, 0, 1, 1, 1, 1, 0);
        drive(0, 1, 2, 0, 0, 1, 1, 0);
        repeat (4) drive(0, 0, 0, 1, 0, 1, 1, 0);
        drive(0, 1, 12, 1, 1, 1, 1, 0);
        drive(1, 1, 5, 1, 1, 1, 1, 0);
        drive(0, 1, 3, 1, 1, 1, 1, 0);
        // Full range up, direction flip, down through zero.
        drive(1, 0, 0, 0, 1, 0, 1, 1);
        repeat (16) drive(0, 0, 0, 1, 1, 0, 1, 0);
        repeat (17) drive(0, 0, 0, 1, 0, 0, 1, 0);
        // Cascade from 00 through 99 back to 00.
        drive(0, 0, 0, 0, 1, 0, 1, 1);
        repeat (101) drive(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 1, 1, 0);
        // Random mix.
        repeat (400)
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) != 0, $urandom_range(0, 49) == 0);

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard.drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
